// File: rtl/bundler_bits_stream.sv
// ---------------------------------------------------------------------------
// bundler_bits_stream
//
// Streaming majority-vote bundler for HDC encoding. A run of num_hvs
// hypervector slices arrives one PAR_BITS-wide slice per accepted beat. The
// block counts the ones in each bit lane and then emits the bundled slice
// (per-lane majority). Even-count ties take the tie_bits value that was
// latched at start. The run length is clamped to MAX_HVS.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      begin a run (sampled only in IDLE)
//   num_hvs    run length, latched on start
//   tie_bits   per-lane tie-break value, latched on start
//   in_valid   in_bits is valid
//   in_ready   high in ACCUM; a beat is taken when in_valid && in_ready
//   in_bits    one hypervector slice
//   out_valid  high in OUT; out_bits holds the bundled result
//   out_ready  consumer accepts the result
//   out_bits   bundled slice
//   busy       high in ACCUM or OUT
// ---------------------------------------------------------------------------
module bundler_bits_stream #(
    parameter int unsigned PAR_BITS = 2,
    parameter int unsigned MAX_HVS  = 16,
    parameter int unsigned CNT_W    = $clog2(MAX_HVS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_hvs,
    input  logic [PAR_BITS-1:0] tie_bits,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PAR_BITS-1:0] in_bits,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PAR_BITS-1:0] out_bits,
    output logic                busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]                      state;
    logic [CNT_W-1:0]                n_lat;
    logic [PAR_BITS-1:0]             tie_lat;
    logic [CNT_W-1:0]                beat_cnt;
    logic [PAR_BITS-1:0][CNT_W-1:0]  lane_cnt;

    logic                            accept;
    logic                            last_beat;
    logic [CNT_W-1:0]                n_clamped;
    logic [CNT_W:0]                  beat_next;
    logic [PAR_BITS-1:0][CNT_W-1:0]  lane_next;
    logic [PAR_BITS-1:0][CNT_W:0]    lane_twice;
    logic [PAR_BITS-1:0]             decision;

    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;

    assign n_clamped = (num_hvs > CNT_W'(MAX_HVS)) ? CNT_W'(MAX_HVS) : num_hvs;

    // The decision is taken from the counts including the current beat so the
    // result can be registered on the same edge that accepts the last beat.
    // The doubled count is carried at CNT_W+1 bits to keep 2c from wrapping.
    always_comb begin
        beat_next  = {1'b0, beat_cnt} + {{CNT_W{1'b0}}, 1'b1};
        last_beat  = (beat_next == {1'b0, n_lat});
        lane_next  = lane_cnt;
        lane_twice = '0;
        decision   = '0;
        for (int unsigned i = 0; i < PAR_BITS; i++) begin
            lane_next[i]  = lane_cnt[i] + {{(CNT_W-1){1'b0}}, in_bits[i]};
            lane_twice[i] = {lane_next[i], 1'b0};
            if (lane_twice[i] > {1'b0, n_lat}) begin
                decision[i] = 1'b1;
            end else if (lane_twice[i] < {1'b0, n_lat}) begin
                decision[i] = 1'b0;
            end else begin
                decision[i] = tie_lat[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            n_lat    <= '0;
            tie_lat  <= '0;
            beat_cnt <= '0;
            lane_cnt <= '0;
            out_bits <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat    <= n_clamped;
                        tie_lat  <= tie_bits;
                        beat_cnt <= '0;
                        lane_cnt <= '0;
                        if (n_clamped == '0) begin
                            out_bits <= tie_bits;
                            state    <= S_OUT;
                        end else begin
                            state    <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        beat_cnt <= beat_next[CNT_W-1:0];
                        lane_cnt <= lane_next;
                        if (last_beat) begin
                            out_bits <= decision;
                            state    <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bundler_bits_stream.sv
// ---------------------------------------------------------------------------
// tb_bundler_bits_stream
//
// Scoreboard bench for bundler_bits_stream. The driver computes each run's
// expected bundled slice from per-lane one counts and queues it. A negedge
// monitor pops an entry and compares it at every output handshake. The
// monitor also checks that out_bits stays stable while the output is stalled.
// ---------------------------------------------------------------------------
module tb_bundler_bits_stream;

    localparam int unsigned PAR_BITS = 2;
    localparam int unsigned MAX_HVS  = 16;
    localparam int unsigned CNT_W    = $clog2(MAX_HVS + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [CNT_W-1:0]    num_hvs = '0;
    logic [PAR_BITS-1:0] tie_bits = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [PAR_BITS-1:0] in_bits = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [PAR_BITS-1:0] out_bits;
    logic                busy;

    bundler_bits_stream #(
        .PAR_BITS(PAR_BITS),
        .MAX_HVS (MAX_HVS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_hvs  (num_hvs),
        .tie_bits (tie_bits),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bits  (in_bits),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bits (out_bits),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [PAR_BITS-1:0] exp_q[$];
    logic [PAR_BITS-1:0] beats[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // Reference: per-lane majority over the first n beats, with ties taking tie.
    function automatic logic [PAR_BITS-1:0] bundle_model(input int n, input logic [PAR_BITS-1:0] tie);
        logic [PAR_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < PAR_BITS; i++) begin
            int c;
            c = 0;
            for (int k = 0; k < n; k++) c += int'(beats[k][i]);
            if (2 * c > n)      r[i] = 1'b1;
            else if (2 * c < n) r[i] = 1'b0;
            else                r[i] = tie[i];
        end
        return r;
    endfunction

    // Monitor: compares at output handshakes and checks stability under stall.
    logic                prev_stall = 1'b0;
    logic [PAR_BITS-1:0] prev_bits  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid)
                check("out_bits_stable", 32'(out_bits), 32'(prev_bits));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    check("out_bits", 32'(out_bits), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_bits  = out_bits;
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send_beat(input logic [PAR_BITS-1:0] b, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_bits  = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("beat_timeout", 32'(in_ready), 32'd1);
    endtask

    // One full run over beats[0..]. gap: idle cycles between beats (start is
    // pulsed there and must be ignored). hold: cycles out_ready stays low in OUT.
    task automatic run(input int req_n, input logic [PAR_BITS-1:0] tie, input int gap, input int hold);
        int  n;
        bit  ok;
        n = (req_n > int'(MAX_HVS)) ? int'(MAX_HVS) : req_n;
        wait_idle();
        out_ready = (hold == 0);
        start     = 1'b1;
        num_hvs   = CNT_W'(req_n);
        tie_bits  = tie;
        exp_q.push_back(bundle_model(n, tie));
        @(posedge clk); #1;
        start    = 1'b0;
        tie_bits = ~tie;
        num_hvs  = '0;
        for (int k = 0; k < n; k++) begin
            send_beat(beats[k], ok);
            if (k != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    start   = 1'b1;
                    num_hvs = CNT_W'(1);
                    @(posedge clk); #1;
                    start   = 1'b0;
                end
            end
        end
        check("out_valid_latency", 32'(out_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            start    = 1'b1;
            num_hvs  = CNT_W'(1);
            in_valid = 1'b1;
            in_bits  = PAR_BITS'($urandom);
            @(posedge clk); #1;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
    endtask

    task automatic set_beats5(input logic [PAR_BITS-1:0] a, b, c, d, e);
        beats[0] = a; beats[1] = b; beats[2] = c; beats[3] = d; beats[4] = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_bits",  32'(out_bits),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1
        set_beats5(2'b00, 2'b00, 2'b01, 2'b10, 2'b10);
        run(5, 2'b00, 0, 0);
        // T2
        set_beats5(2'b10, 2'b00, 2'b11, 2'b01, 2'b01);
        run(5, 2'b00, 0, 0);
        set_beats5(2'b10, 2'b11, 2'b11, 2'b10, 2'b11);
        run(5, 2'b00, 0, 0);
        // T3
        beats[0] = 2'b01; beats[1] = 2'b10; beats[2] = 2'b11; beats[3] = 2'b00;
        run(4, 2'b10, 0, 0);
        run(4, 2'b01, 0, 0);
        // T4
        set_beats5(2'b11, 2'b01, 2'b00, 2'b11, 2'b10);
        run(5, 2'b00, 2, 3);
        // T5: reset mid-run discards everything
        wait_idle();
        start = 1'b1; num_hvs = CNT_W'(5); tie_bits = 2'b11;
        @(posedge clk); #1;
        start = 1'b0;
        send_beat(2'b11, ok);
        send_beat(2'b11, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        beats[0] = 2'b11; beats[1] = 2'b11; beats[2] = 2'b00;
        run(3, 2'b00, 0, 0);
        // T6: zero length and clamped length
        run(0, 2'b01, 0, 0);
        for (int k = 0; k < 32; k++) beats[k] = 2'b11;
        run(int'(MAX_HVS) + 5, 2'b00, 0, 0);
        // Minimum run
        beats[0] = 2'b10;
        run(1, 2'b01, 0, 0);

        // Randomized runs, including lengths above MAX_HVS
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 32; k++) beats[k] = PAR_BITS'($urandom);
            run(int'($urandom_range(0, MAX_HVS + 3)), PAR_BITS'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
